ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Iterative multi-cycle divider for the EX stage.
- Consumes the operands and ALU opcode held in the ID/EX pipeline register; the EX logic decodes DIV/DIVU into start and signedness.
- Produces the 64-bit HI/LO result. EX holds a stall request while start=1 and ready=0.
- Radix-2 restoring algorithm: one quotient bit per clock.

Parameters:
- DIV_W, 32, operand width. Result width is 2*DIV_W. The iteration counter is clog2(DIV_W)+1 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1  in  DIV_W  dividend; sampled with start
- opdata2  in  DIV_W  divisor; sampled with start
- start  in  1  request; held high by EX until the result is consumed
- annul  in  1  cancel; pipeline flush or branch squash of the divide instruction
- result  out  2*DIV_W  {remainder, quotient}; upper half to HI, lower half to LO
- ready  out  1  result valid

Behaviour:
- Reset: state=FREE, cnt=0, result=0, ready=0; takes effect immediately and asynchronously in any state. Internal operand registers are cleared.
- States: FREE, BYZERO, ON, END. Encodings are shared constants.
- FREE, start=1, annul=0:
  - opdata2==0: go to BYZERO.
  - otherwise: latch |opdata1| and |opdata2| (two's-complement negate only when signed_div and the MSB is set); latch signed_div, sign1 and sign2; cnt=0; go to ON.
  - start=0 or annul=1: stay in FREE, outputs 0.
- BYZERO: next edge go to END with result=0.
- ON, annul=1: go to FREE immediately; ready stays 0; partial state is discarded.
- ON, cnt<DIV_W: one restoring step per edge.
  - Shift the {partial remainder, dividend} register left by 1.
  - Trial-subtract the divisor from the upper DIV_W+1 bits.
  - If non-negative, keep the difference and set the quotient LSB to 1; else keep the shifted value and set the LSB to 0.
  - cnt increments.
- ON, cnt==DIV_W:
  - Quotient sign correction: negate when sign1^sign2 (signed only).
  - Remainder sign correction: negate when sign1 (signed only).
  - Register the result, ready=1, go to END.
- END:
  - result and ready are held stable while start=1.
  - start=0 or annul=1: go to FREE; result=0 and ready=0 on that edge.
- Latency: start sampled at edge E0 gives ready=1 after edge E(DIV_W+1), i.e. E33 for 32 bits. Divide-by-zero gives ready after E1.
- Start while not FREE: ignored. Operand changes after E0: ignored (latched copies are used).
- Overflow (signed): -2^(W-1) / -1 gives quotient 0x80000000 (wraps) and remainder 0; no trap.
- Unsigned: opdata1 and opdata2 are used verbatim; no sign correction.
- Simultaneous start and annul in FREE: annul wins; remain in FREE.
- Width rule: the trial subtraction is DIV_W+1 bits wide; its MSB is the borrow that decides the quotient bit.
- ready and result are registered, with no combinational path from the inputs.

Decomposition:
- The shared defines package holds:
  - DivFree, DivByZero, DivOn, DivEnd (2-bit state encodings)
  - DivResultReady/NotReady, DivStart/Stop
  - DoubleRegBus (63:0)
  - the EX aluop codes for DIV and DIVU
- No sub-module: the single iteration step stays inline, as one combinational subtraction feeding the state register.

Test Plan:
- Unsigned 100/7: start held → ready rises after the 33rd edge following the start edge; result = {0x00000002, 0x0000000E}. Hold start 3 more cycles → result unchanged. Drop start → ready=0 and result=0 next edge.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Same operands unsigned → quotient 0x7FFFFFFC, remainder 0x00000001.
- Divide by zero, signed 5/0 → ready after the 2nd edge, result = 0, no ON state visited.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Annul at cnt=10 → FREE next edge, ready never asserts. A fresh start of 9/3 the following cycle → {0, 3} after the full latency.
- Async reset pulse mid-ON (between clock edges) → result=0 and ready=0 before the next edge. After release with start=1, a full-length divide restarts from FREE.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared constants for the EX-stage divider: FSM encodings, handshake levels
// and the ALU opcodes that EX decodes into a divide request.
package ex_div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam int DoubleRegBus = 64;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider, one quotient bit per clock. Result is
// {remainder, quotient}, held while EX keeps start high.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [DIV_W-1:0]     opdata1,
    input  logic [DIV_W-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*DIV_W-1:0]   result,
    output logic                 ready
);

    localparam int CNT_W = $clog2(DIV_W) + 1;

    div_state_t         state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [DIV_W-1:0]   rem, rem_nx;
    logic [DIV_W-1:0]   quo, quo_nx;
    logic [DIV_W-1:0]   dvsr, dvsr_nx;
    logic               sgn, sgn_nx, sign1, sign1_nx, sign2, sign2_nx;
    logic [2*DIV_W-1:0] result_nx;
    logic               ready_nx;

    // The partial remainder stays below 2*divisor, so a DIV_W+1 bit trial
    // subtraction wraps into its MSB exactly when it would go negative.
    logic [DIV_W:0]     partial, diff;
    logic [DIV_W-1:0]   q_fix, r_fix;

    assign partial = {rem, quo[DIV_W-1]};
    assign diff    = partial - {1'b0, dvsr};
    assign q_fix   = (sgn && (sign1 ^ sign2)) ? -quo : quo;
    assign r_fix   = (sgn && sign1) ? -rem : rem;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rem_nx    = rem;
        quo_nx    = quo;
        dvsr_nx   = dvsr;
        sgn_nx    = sgn;
        sign1_nx  = sign1;
        sign2_nx  = sign2;
        result_nx = result;
        ready_nx  = ready;
        case (state)
            DivFree: begin
                result_nx = '0;
                ready_nx  = DivResultNotReady;
                if (start == DivStart && !annul) begin
                    if (opdata2 == '0) begin
                        state_nx = DivByZero;
                    end else begin
                        sgn_nx   = signed_div;
                        sign1_nx = opdata1[DIV_W-1];
                        sign2_nx = opdata2[DIV_W-1];
                        quo_nx   = (signed_div && opdata1[DIV_W-1]) ? -opdata1 : opdata1;
                        dvsr_nx  = (signed_div && opdata2[DIV_W-1]) ? -opdata2 : opdata2;
                        rem_nx   = '0;
                        cnt_nx   = '0;
                        state_nx = DivOn;
                    end
                end
            end
            DivByZero: begin
                result_nx = '0;
                ready_nx  = DivResultReady;
                state_nx  = DivEnd;
            end
            DivOn: begin
                if (annul) begin
                    result_nx = '0;
                    ready_nx  = DivResultNotReady;
                    cnt_nx    = '0;
                    state_nx  = DivFree;
                end else if (cnt != CNT_W'(DIV_W)) begin
                    if (!diff[DIV_W]) begin
                        rem_nx = diff[DIV_W-1:0];
                        quo_nx = {quo[DIV_W-2:0], 1'b1};
                    end else begin
                        rem_nx = partial[DIV_W-1:0];
                        quo_nx = {quo[DIV_W-2:0], 1'b0};
                    end
                    cnt_nx = cnt + 1'b1;
                end else begin
                    result_nx = {r_fix, q_fix};
                    ready_nx  = DivResultReady;
                    state_nx  = DivEnd;
                end
            end
            DivEnd: begin
                if (start == DivStop || annul) begin
                    result_nx = '0;
                    ready_nx  = DivResultNotReady;
                    state_nx  = DivFree;
                end
            end
            default: state_nx = DivFree;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= DivFree;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            sgn    <= 1'b0;
            sign1  <= 1'b0;
            sign2  <= 1'b0;
            result <= '0;
            ready  <= DivResultNotReady;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            rem    <= rem_nx;
            quo    <= quo_nx;
            dvsr   <= dvsr_nx;
            sgn    <= sgn_nx;
            sign1  <= sign1_nx;
            sign2  <= sign2_nx;
            result <= result_nx;
            ready  <= ready_nx;
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Bench for ex_div: arithmetic reference model with a latency countdown,
// per-cycle compare, plus directed literal cases.
module tb_ex_div;

    localparam int W = 32;
    localparam int LAT = W + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           signed_div = 1'b0;
    logic [W-1:0]   opdata1 = '0;
    logic [W-1:0]   opdata2 = '0;
    logic           start = 1'b0;
    logic           annul = 1'b0;
    logic [2*W-1:0] result;
    logic           ready;

    int checks = 0;
    int errors = 0;

    ex_div #(.DIV_W(W)) dut (
        .clk(clk), .rst(rst), .signed_div(signed_div),
        .opdata1(opdata1), .opdata2(opdata2), .start(start), .annul(annul),
        .result(result), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Plain arithmetic reference: SV division truncates toward zero and the
    // remainder takes the dividend's sign, matching DIV semantics.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return 64'h0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Model: idle / counting down to ready / holding the answer.
    int          m_ph = 0;
    int          m_left = 0;
    logic        m_zero = 1'b0;
    logic        m_ready = 1'b0;
    logic [63:0] m_result = '0;
    logic [63:0] m_ans = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_ready <= 1'b0; m_result <= '0; m_left <= 0;
        end else begin
            case (m_ph)
                0: if (start && !annul) begin
                    m_ans  <= ref_div(signed_div, opdata1, opdata2);
                    m_zero <= (opdata2 == 0);
                    m_left <= (opdata2 == 0) ? 1 : W + 1;
                    m_ph   <= 1;
                end
                1: if (annul && !m_zero) begin
                    m_ph <= 0;
                end else if (m_left == 1) begin
                    m_ready <= 1'b1; m_result <= m_ans; m_ph <= 2;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (!start || annul) begin
                    m_ph <= 0; m_ready <= 1'b0; m_result <= '0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_ready", 64'(ready), 64'(m_ready));
            chk("cyc_result", result, m_result);
        end
    end

    task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
        signed_div = sg; opdata1 = a; opdata2 = b; start = 1'b1;
    endtask

    // Counts edges from the start-sampling edge until ready; scrambles the
    // operands right after that edge since only latched copies may matter.
    task automatic wait_ready(output int n);
        logic got;
        got = 1'b0;
        n = 0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                opdata1 = $urandom; opdata2 = $urandom;
                signed_div = 1'($urandom_range(0, 1));
            end
            got = ready;
        end
    endtask

    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_lat, input int hold, input string nm);
        int n;
        launch(sg, a, b);
        wait_ready(n);
        chk({nm, "_lat"}, 64'(n), 64'(exp_lat));
        chk({nm, "_res"}, result, exp);
        repeat (hold) begin
            @(posedge clk); #1;
            chk({nm, "_hold_rdy"}, 64'(ready), 64'h1);
            chk({nm, "_hold_res"}, result, exp);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_drop_rdy"}, 64'(ready), 64'h0);
        chk({nm, "_drop_res"}, result, 64'h0);
    endtask

    initial begin
        #3200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic sg;
        logic [31:0] a, b;
        int sel;

        #3;
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_result", result, 64'h0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        chk("model_u100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        chk("model_s-7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        chk("model_ovf", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, LAT, 3, "u100_7");
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, LAT, 1, "s-7_2");
        run_div(1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, LAT, 1, "u-7_2");
        run_div(1'b1, 32'd5, 32'd0, 64'h0, 2, 2, "div0");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, LAT, 1, "ovf");
        run_div(1'b0, 32'hFFFFFFFF, 32'h80000001, 64'h7FFFFFFE_00000001, LAT, 0, "u_bigdiv");

        // Annul after ten iterations, then one cycle of start+annul in FREE.
        launch(1'b1, -32'sd1000, 32'd7);
        repeat (11) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk); #1;
        chk("annul_rdy", 64'(ready), 64'h0);
        opdata1 = 32'd9; opdata2 = 32'd3; signed_div = 1'b0;
        @(posedge clk); #1;
        chk("annul_hold_rdy", 64'(ready), 64'h0);
        annul = 1'b0;
        run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, LAT, 0, "after_annul");

        // Async reset mid-ON, then a full-length divide with start held.
        launch(1'b0, 32'd100, 32'd7);
        repeat (15) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        chk("arst_on_rdy", 64'(ready), 64'h0);
        chk("arst_on_res", result, 64'h0);
        #1 rst = 1'b0;
        launch(1'b0, 32'd1000, 32'd9);
        wait_ready(n);
        chk("arst_restart_lat", 64'(n), 64'(LAT));
        chk("arst_restart_res", result, 64'h00000001_0000006F);
        // Async reset while holding a finished result.
        @(posedge clk); #4 rst = 1'b1;
        #1;
        chk("arst_end_rdy", 64'(ready), 64'h0);
        chk("arst_end_res", result, 64'h0);
        #1 rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'h0;
                1: b = 32'h1;
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_div(sg, a, b, ref_div(sg, a, b), (b == 0) ? 2 : LAT,
                    $urandom_range(0, 2), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
